// File: rtl/bus_mailbox.sv
// bus_mailbox: CPU-bus mapped TX/RX byte FIFOs in a 4-byte window; optional IRQ under `BUS_MAILBOX_IRQ_EN
module bus_mailbox #(
    parameter logic [15:0] BASE_ADDR = 16'h1f80,
    parameter int          DEPTH     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address_bus,
    inout  wire  [7:0]  data_bus,
    input  logic        r,
    input  logic        w,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [7:0]    r_tx_mem [DEPTH];
    logic [7:0]    r_rx_mem [DEPTH];
    logic [PW-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    logic          r_rq, r_wq, r_ovf;
    logic [7:0]    r_rd_q;
    logic [1:0]    w_ctl;
    logic          w_sel, w_rd, w_wr, w_data_wr, w_flush;
    logic          w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
    logic          w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic [7:0]    w_status, w_rd_val;

    assign w_sel      = address_bus[15:2] == BASE_ADDR[15:2];
    assign w_rd       = w_sel & r & ~r_rq & ~w;
    assign w_wr       = w_sel & w & ~r_wq & ~r;
    assign w_data_wr  = w_wr & (address_bus[1:0] == 2'd0);
    assign w_flush    = w_wr & (address_bus[1:0] == 2'd2) & data_bus[7];
    assign w_tx_empty = r_tx_wp == r_tx_rp;
    assign w_tx_full  = (r_tx_wp[AW] != r_tx_rp[AW]) && (r_tx_wp[AW-1:0] == r_tx_rp[AW-1:0]);
    assign w_rx_empty = r_rx_wp == r_rx_rp;
    assign w_rx_full  = (r_rx_wp[AW] != r_rx_rp[AW]) && (r_rx_wp[AW-1:0] == r_rx_rp[AW-1:0]);
    // a TX pop in the same cycle frees the slot, so a full TX can still take a write
    assign w_tx_pop   = ~w_tx_empty & tx_ready;
    assign w_tx_push  = w_data_wr & (~w_tx_full | w_tx_pop);
    assign w_rx_push  = rx_valid & rx_ready;
    assign w_rx_pop   = w_rd & (address_bus[1:0] == 2'd0) & ~w_rx_empty;
    assign w_status   = {4'b0, r_ovf, w_tx_empty, ~w_tx_full, ~w_rx_empty};
    assign w_rd_val   = (address_bus[1:0] == 2'd0) ? (w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp[AW-1:0]]) :
                        (address_bus[1:0] == 2'd1) ? w_status :
                        (address_bus[1:0] == 2'd2) ? {6'b0, w_ctl} : 8'h00;

    assign tx_data  = r_tx_mem[r_tx_rp[AW-1:0]];
    assign tx_valid = ~w_tx_empty;
    assign rx_ready = ~w_rx_full & reset;
    assign data_bus = (w_sel & r & reset) ? r_rd_q : 8'bz;

    // strobe history for edge detection, read capture and sticky overflow
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rq   <= 1'b1;
            r_wq   <= 1'b1;
            r_rd_q <= 8'h00;
            r_ovf  <= 1'b0;
        end else begin
            r_rq <= r;
            r_wq <= w;
            if (w_rd)
                r_rd_q <= w_rd_val;
            if (w_flush)
                r_ovf <= 1'b0;
            else if (w_data_wr & ~w_tx_push)
                r_ovf <= 1'b1;
        end
    end

    // TX pointers; flush overrides any same-cycle push
    always_ff @(posedge clk) begin
        if (!reset || w_flush) begin
            r_tx_wp <= '0;
            r_tx_rp <= '0;
        end else begin
            if (w_tx_push)
                r_tx_wp <= r_tx_wp + PW'(1);
            if (w_tx_pop)
                r_tx_rp <= r_tx_rp + PW'(1);
        end
    end

    // TX storage takes the CPU byte
    always_ff @(posedge clk) begin
        if (w_tx_push)
            r_tx_mem[r_tx_wp[AW-1:0]] <= data_bus;
    end

    // RX pointers; flush overrides any same-cycle push
    always_ff @(posedge clk) begin
        if (!reset || w_flush) begin
            r_rx_wp <= '0;
            r_rx_rp <= '0;
        end else begin
            if (w_rx_push)
                r_rx_wp <= r_rx_wp + PW'(1);
            if (w_rx_pop)
                r_rx_rp <= r_rx_rp + PW'(1);
        end
    end

    // RX storage takes the stream byte
    always_ff @(posedge clk) begin
        if (w_rx_push)
            r_rx_mem[r_rx_wp[AW-1:0]] <= rx_data;
    end

`ifdef BUS_MAILBOX_IRQ_EN
    logic [1:0] r_ctl;
    logic       r_irq;

    // interrupt enables and registered level interrupt
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ctl <= 2'b00;
            r_irq <= 1'b0;
        end else begin
            if (w_wr && address_bus[1:0] == 2'd2)
                r_ctl <= data_bus[1:0];
            r_irq <= (r_ctl[0] & ~w_rx_empty) | (r_ctl[1] & w_tx_empty);
        end
    end

    assign w_ctl = r_ctl;
    assign irq   = r_irq;
`else
    assign w_ctl = 2'b00;
    assign irq   = 1'b0;
`endif
endmodule

// File: tb/tb_bus_mailbox.sv
// tb_bus_mailbox: queue-based reference model with per-cycle compare, directed cases and random traffic
module tb_bus_mailbox;
    localparam int          DEPTH = 8;
    localparam logic [15:0] BASE  = 16'h1f80;

    logic        clk = 1'b0, reset = 1'b0, r = 1'b0, w = 1'b0;
    logic        tx_ready = 1'b0, rx_valid = 1'b0;
    logic [15:0] address_bus = 16'h0000;
    logic [7:0]  rx_data = 8'h00, tb_d = 8'h00, d;
    logic [7:0]  tx_data;
    logic        tx_valid, rx_ready, irq, tb_de;
    wire  [7:0]  data_bus;

    int checks = 0, failures = 0;

    logic [7:0] txq[$], rxq[$];
    logic [7:0] m_rdq = 8'h00;
    logic [1:0] m_ctl = 2'b00;
    logic       m_ovf = 1'b0, m_irq = 1'b0, m_pr = 1'b1, m_pw = 1'b1;

    assign tb_de    = w & ~r;
    assign data_bus = tb_de ? tb_d : 8'bz;

    bus_mailbox #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .address_bus(address_bus), .data_bus(data_bus),
        .r(r), .w(w), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_ne(input string name, input logic [7:0] got, input logic [7:0] bad);
        checks++;
        if (got === bad) begin
            failures++;
            $display("FAIL %s: got %h expected released bus (not %h) at %0t", name, got, bad, $time);
        end
    endtask

    // reference model: advances on every edge, then outputs are compared 1 time unit later
    always @(posedge clk) begin
        logic       sel, ra, wa, txp, rxp, txfull, nirq;
        logic [1:0] off;
        logic [7:0] st;
        if (!reset) begin
            txq.delete();
            rxq.delete();
            m_rdq = 8'h00;
            m_ctl = 2'b00;
            m_ovf = 1'b0;
            m_irq = 1'b0;
            m_pr  = 1'b1;
            m_pw  = 1'b1;
        end else begin
            sel    = address_bus[15:2] == BASE[15:2];
            off    = address_bus[1:0];
            ra     = sel && r && !m_pr && !w;
            wa     = sel && w && !m_pw && !r;
            st     = {4'b0, m_ovf, txq.size() == 0, txq.size() < DEPTH, rxq.size() != 0};
            nirq   = (m_ctl[0] && rxq.size() != 0) || (m_ctl[1] && txq.size() == 0);
            txp    = txq.size() != 0 && tx_ready;
            txfull = txq.size() == DEPTH;
            rxp    = rx_valid && rxq.size() < DEPTH;
            if (ra) begin
                if (off == 2'd0) begin
                    if (rxq.size() != 0) m_rdq = rxq.pop_front();
                    else m_rdq = 8'h00;
                end else if (off == 2'd1) m_rdq = st;
                else if (off == 2'd2) m_rdq = {6'b0, m_ctl};
                else m_rdq = 8'h00;
            end
            if (txp) txq.delete(0);
            if (rxp) rxq.push_back(rx_data);
            if (wa && off == 2'd0) begin
                if (!txfull || txp) txq.push_back(tb_d);
                else m_ovf = 1'b1;
            end
            if (wa && off == 2'd2) begin
`ifdef BUS_MAILBOX_IRQ_EN
                m_ctl = tb_d[1:0];
`endif
                if (tb_d[7]) begin
                    txq.delete();
                    rxq.delete();
                    m_ovf = 1'b0;
                end
            end
            m_pr  = r;
            m_pw  = w;
            m_irq = nirq;
        end
        #1;
        chk("tx_valid", {7'b0, tx_valid}, {7'b0, txq.size() != 0});
        if (txq.size() != 0) chk("tx_data", tx_data, txq[0]);
        chk("rx_ready", {7'b0, rx_ready}, {7'b0, reset && rxq.size() < DEPTH});
        chk("irq", {7'b0, irq}, {7'b0, m_irq});
        if (address_bus[15:2] == BASE[15:2] && r && reset) chk("rd_data", data_bus, m_rdq);
        else if (!tb_de && m_rdq != 8'h00) chk_ne("bus_release", data_bus, m_rdq);
    end

    task automatic bus_write(input logic [15:0] a, input logic [7:0] v);
        @(negedge clk);
        address_bus = a;
        tb_d = v;
        w = 1'b1;
        @(negedge clk);
        w = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] v);
        @(negedge clk);
        address_bus = a;
        r = 1'b1;
        @(posedge clk);
        #2 v = data_bus;
        @(negedge clk);
        r = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rx_ready", {7'b0, rx_ready}, 8'h00);
        chk("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
        reset = 1'b1;
        #1 chk("rel_rx_ready", {7'b0, rx_ready}, 8'h01);

        bus_write(16'h1f80, 8'h41);
        chk("t1_tx_valid", {7'b0, tx_valid}, 8'h01);
        chk("t1_tx_data", tx_data, 8'h41);
        @(negedge clk) tx_ready = 1'b1;
        @(negedge clk) tx_ready = 1'b0;
        chk("t1_tx_drained", {7'b0, tx_valid}, 8'h00);
        bus_read(16'h1f81, d); chk("t1_status", d, 8'h06);

        @(negedge clk) begin rx_data = 8'h5a; rx_valid = 1'b1; end
        @(negedge clk) rx_valid = 1'b0;
        bus_read(16'h1f80, d); chk("t2_pop", d, 8'h5a);
        bus_read(16'h1f80, d); chk("t2_empty_pop", d, 8'h00);
        bus_read(16'h1f81, d); chk("t2_status", d, 8'h06);

        @(negedge clk) begin rx_data = 8'h11; rx_valid = 1'b1; end
        @(negedge clk) rx_data = 8'h22;
        @(negedge clk) begin rx_valid = 1'b0; address_bus = 16'h1f80; r = 1'b1; end
        repeat (5) @(negedge clk);
        chk("t3_held_read", data_bus, 8'h11);
        r = 1'b0;
        bus_read(16'h1f80, d); chk("t3_remaining", d, 8'h22);

        for (int i = 0; i < 9; i++) bus_write(16'h1f80, 8'(i + 1));
        bus_read(16'h1f81, d); chk("t4_overflow", d, 8'h08);
        bus_write(16'h1f82, 8'h80);
        bus_read(16'h1f81, d); chk("t4_flushed", d, 8'h06);

        bus_write(16'h1f82, 8'h01);
        @(negedge clk) begin rx_data = 8'h77; rx_valid = 1'b1; end
        @(negedge clk) rx_valid = 1'b0;
        @(negedge clk);
`ifdef BUS_MAILBOX_IRQ_EN
        chk("t5_irq_set", {7'b0, irq}, 8'h01);
        bus_read(16'h1f82, d); chk("t5_ctrl", d, 8'h01);
`else
        chk("t5_irq_off", {7'b0, irq}, 8'h00);
        bus_read(16'h1f82, d); chk("t5_ctrl", d, 8'h00);
`endif
        bus_read(16'h1f80, d); chk("t5_pop", d, 8'h77);
        @(negedge clk);
        chk("t5_irq_clear", {7'b0, irq}, 8'h00);
        bus_write(16'h1f82, 8'h00);

        bus_read(16'h1f81, d); chk("t6_status", d, 8'h06);
        @(negedge clk) begin address_bus = 16'h1f84; r = 1'b1; end
        @(posedge clk) #2 chk_ne("t6_unselected", data_bus, 8'h06);
        @(negedge clk) r = 1'b0;
        @(negedge clk) begin address_bus = 16'h1f81; r = 1'b1; end
        @(posedge clk) #2 chk("t6_read_on", data_bus, 8'h06);
        #1 reset = 1'b0;
        #1 chk_ne("t6_reset_release", data_bus, 8'h06);
        @(negedge clk) r = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(negedge clk) rx_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            rx_data = 8'(8'hc0 + i);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        chk("t6_rx_full", {7'b0, rx_ready}, 8'h00);
        bus_read(16'h1f81, d); chk("t6_status_full", d, 8'h07);
        bus_write(16'h1f82, 8'h80);
        chk("t6_rx_flushed", {7'b0, rx_ready}, 8'h01);

        for (int i = 0; i < 3000; i++) begin
            logic [1:0] o;
            int         rate;
            @(negedge clk);
            o           = 2'($urandom);
            rate        = ((i / 500) % 2 == 0) ? 1 : 7;
            reset       = $urandom_range(0, 299) != 0;
            address_bus = ($urandom_range(0, 7) == 0) ? BASE + 16'd4 + 16'(o) : BASE + 16'(o);
            r           = $urandom_range(0, 2) == 0;
            w           = $urandom_range(0, 2) == 0;
            tb_d        = 8'($urandom);
            if ($urandom_range(0, 5) != 0) tb_d[7] = 1'b0;
            tx_ready    = $urandom_range(0, 9) < rate;
            rx_valid    = $urandom_range(0, 9) >= rate;
            rx_data     = 8'($urandom);
        end
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
